// File: rtl/bsg_chip_reset_cord_sequencer_if.sv
// Tag-client side bundle of the reset/cord sequencer.
//   tag_v_i     : per-channel new-payload strobe (one-cycle pulse)
//   tag_reset_i : per-channel requested reset bit, valid with tag_v_i
//   tag_cord_i  : per-channel cord, valid with tag_v_i
//   reset_o     : registered per-channel reset to the domains
//   cord_o      : registered per-channel cord
//   done_o      : all channels out of reset
//   err_o       : sticky, a cord write arrived while its channel was running
// master = tag-client/toplevel side, slave = sequencer.
interface bsg_chip_reset_cord_sequencer_if #(
  parameter int unsigned num_ch_p     = 4,
  parameter int unsigned cord_width_p = 7
);

  logic [num_ch_p-1:0]                   tag_v_i;
  logic [num_ch_p-1:0]                   tag_reset_i;
  logic [num_ch_p-1:0][cord_width_p-1:0] tag_cord_i;
  logic [num_ch_p-1:0]                   reset_o;
  logic [num_ch_p-1:0][cord_width_p-1:0] cord_o;
  logic                                  done_o;
  logic                                  err_o;

  modport master (
    output tag_v_i, tag_reset_i, tag_cord_i,
    input  reset_o, cord_o, done_o, err_o
  );

  modport slave (
    input  tag_v_i, tag_reset_i, tag_cord_i,
    output reset_o, cord_o, done_o, err_o
  );

endinterface

// File: rtl/bsg_chip_reset_cord_sequencer.sv
// Reset/cord sequencer: captures per-channel reset requests and cords from
// the tag clients, holds every domain in reset while any request is set, and
// once all requests clear releases the domains one by one in index order.
//   clk_i   : router/core clock
//   reset_i : asynchronous active-high reset
//   bus     : slave modport carrying tag strobes/payloads and the
//             registered reset_o / cord_o / done_o / err_o outputs
module bsg_chip_reset_cord_sequencer #(
  parameter int unsigned num_ch_p      = 4,
  parameter int unsigned cord_width_p  = 7,
  parameter int unsigned hold_cycles_p = 16,
  parameter int unsigned gap_cycles_p  = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  bsg_chip_reset_cord_sequencer_if.slave   bus
);

  localparam int unsigned cnt_max_lp   = (hold_cycles_p > gap_cycles_p) ? hold_cycles_p : gap_cycles_p;
  localparam int unsigned cnt_width_lp = $clog2(cnt_max_lp) + 1;
  // A single channel still needs a one-bit index register.
  localparam int unsigned idx_width_lp = (num_ch_p > 1) ? $clog2(num_ch_p) : 1;

  localparam logic [cnt_width_lp-1:0] hold_init_lp = cnt_width_lp'(hold_cycles_p - 1);
  localparam logic [cnt_width_lp-1:0] gap_init_lp  = cnt_width_lp'(gap_cycles_p - 1);
  localparam logic [idx_width_lp-1:0] idx_last_lp  = idx_width_lp'(num_ch_p - 1);
  localparam logic [num_ch_p-1:0]     ch_one_lp    = num_ch_p'(1);

  typedef enum logic [1:0] {
    e_assert  = 2'd0,
    e_hold    = 2'd1,
    e_release = 2'd2,
    e_run     = 2'd3
  } state_e;

  state_e                                state_r, state_n;
  logic [cnt_width_lp-1:0]               cnt_r, cnt_n;
  logic [idx_width_lp-1:0]               idx_r, idx_n, idx_inc;
  logic [num_ch_p-1:0]                   reset_r, reset_n;
  logic                                  done_r, done_n;

  logic [num_ch_p-1:0]                   req_r;
  logic [num_ch_p-1:0][cord_width_p-1:0] cord_r;
  logic                                  err_r;

  logic                                  req_any;
  logic                                  cord_drop;

  assign req_any   = |req_r;
  assign idx_inc   = idx_r + idx_width_lp'(1);
  // A strobe on a channel already out of reset cannot update its cord.
  assign cord_drop = |(bus.tag_v_i & ~reset_r);

  // Per-channel request/cord capture and sticky error flag.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      req_r  <= '1;
      cord_r <= '0;
      err_r  <= 1'b0;
    end else begin
      for (int k = 0; k < int'(num_ch_p); k++) begin
        if (bus.tag_v_i[k]) begin
          req_r[k] <= bus.tag_reset_i[k];
          if (reset_r[k]) begin
            cord_r[k] <= bus.tag_cord_i[k];
          end
        end
      end
      if (cord_drop) begin
        err_r <= 1'b1;
      end
    end
  end

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_assert;
      cnt_r   <= '0;
      idx_r   <= '0;
      reset_r <= '1;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      idx_r   <= idx_n;
      reset_r <= reset_n;
      done_r  <= done_n;
    end
  end

  // Next-state and next-output logic; a pending request overrides everything.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    idx_n   = idx_r;
    reset_n = reset_r;
    done_n  = done_r;

    case (state_r)
      e_assert: begin
        reset_n = '1;
        done_n  = 1'b0;
        if (!req_any) begin
          state_n = e_hold;
          cnt_n   = hold_init_lp;
        end
      end

      e_hold: begin
        if (cnt_r == '0) begin
          reset_n = reset_r & ~ch_one_lp;
          idx_n   = '0;
          if (num_ch_p == 1) begin
            state_n = e_run;
            done_n  = 1'b1;
          end else begin
            state_n = e_release;
            cnt_n   = gap_init_lp;
          end
        end else begin
          cnt_n = cnt_r - cnt_width_lp'(1);
        end
      end

      e_release: begin
        if (cnt_r == '0) begin
          idx_n   = idx_inc;
          reset_n = reset_r & ~(ch_one_lp << idx_inc);
          if (idx_inc == idx_last_lp) begin
            state_n = e_run;
            done_n  = 1'b1;
          end else begin
            cnt_n = gap_init_lp;
          end
        end else begin
          cnt_n = cnt_r - cnt_width_lp'(1);
        end
      end

      e_run: begin
        done_n = 1'b1;
      end

      default: begin
        state_n = e_assert;
      end
    endcase

    if (req_any) begin
      state_n = e_assert;
      cnt_n   = '0;
      idx_n   = '0;
      reset_n = '1;
      done_n  = 1'b0;
    end
  end

  assign bus.reset_o = reset_r;
  assign bus.cord_o  = cord_r;
  assign bus.done_o  = done_r;
  assign bus.err_o   = err_r;

endmodule
